// File: rtl/data_memory_responder_pkg.sv
// Shared constants and state encoding for the data-memory responder; LINE_W and
// LINE_OFFSET are also used by the dcache controller so both sides agree on line geometry.
package data_memory_responder_pkg;

  localparam int DMR_LATENCY    = 10;
  localparam int DMR_LINE_W     = 256;
  localparam int DMR_DEPTH_LOG2 = 9;
  localparam int LINE_OFFSET    = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } dmr_state_t;

endpackage

// File: rtl/data_memory_responder_latency_counter.sv
// Up-counter for the request wait: load to 1 on acceptance, count while waiting,
// flag terminal count when the count reaches LATENCY-1.
module data_memory_responder_latency_counter
  import data_memory_responder_pkg::*;
#(
  parameter int LATENCY = DMR_LATENCY
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_clear,
  input  logic i_load,
  input  logic i_enable,
  output logic o_tc
);

  localparam int CNT_W = $clog2(LATENCY);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= CNT_W'(1);
    end else if (i_enable) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_tc = (r_count == CNT_W'(LATENCY - 1));

endmodule

// File: rtl/data_memory_responder.sv
// Off-chip line memory model: fixed-latency read/write with an enable/ack handshake.
//   state | meaning
//   IDLE  | waiting for enable_i; request latched on the accepting edge
//   WAIT  | counting latency; enable_i low aborts with no write and no ack
//   ACK   | one-cycle ack_o; read data on data_o, or write committed at the closing edge
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int LATENCY    = DMR_LATENCY,
  parameter int LINE_W     = DMR_LINE_W,
  parameter int DEPTH_LOG2 = DMR_DEPTH_LOG2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [31:0]       addr_i,
  input  logic [LINE_W-1:0] data_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o
);

  localparam int DEPTH  = 2 ** DEPTH_LOG2;
  localparam int IDX_LO = LINE_OFFSET;
  localparam int IDX_HI = DEPTH_LOG2 + LINE_OFFSET - 1;

  dmr_state_t              r_state;
  dmr_state_t              w_next;
  logic                    w_clear;
  logic                    w_load;
  logic                    w_inc;
  logic                    w_tc;
  logic                    r_write;
  logic [DEPTH_LOG2-1:0]   r_idx;
  logic [LINE_W-1:0]       r_wdata;
  logic                    r_ack;
  logic [LINE_W-1:0]       r_data;
  logic [LINE_W-1:0]       r_mem [DEPTH];
  logic                    w_unused_addr;

  // Offset bits and bits above the index alias away by design.
  assign w_unused_addr = ^{addr_i[31:IDX_HI+1], addr_i[IDX_LO-1:0]};

  data_memory_responder_latency_counter #(
    .LATENCY (LATENCY)
  ) u_latency_counter (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_clear  (w_clear),
    .i_load   (w_load),
    .i_enable (w_inc),
    .o_tc     (w_tc)
  );

  always_comb begin
    w_next  = r_state;
    w_clear = 1'b0;
    w_load  = 1'b0;
    w_inc   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable_i) begin
          w_next = ST_WAIT;
          w_load = 1'b1;
        end
      end
      ST_WAIT: begin
        if (!enable_i) begin
          w_next  = ST_IDLE;
          w_clear = 1'b1;
        end else if (w_tc) begin
          w_next  = ST_ACK;
          w_clear = 1'b1;
        end else begin
          w_inc = 1'b1;
        end
      end
      ST_ACK: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next  = ST_IDLE;
        w_clear = 1'b1;
      end
    endcase
  end

  // Outputs are registered off the next state so ack_o lines up with the ACK state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
      r_ack   <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      r_ack   <= (w_next == ST_ACK);
      if ((w_next == ST_ACK) && !r_write) begin
        r_data <= r_mem[r_idx];
      end else begin
        r_data <= '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if ((r_state == ST_IDLE) && enable_i) begin
      r_write <= write_i;
      r_idx   <= addr_i[IDX_HI:IDX_LO];
      r_wdata <= data_i;
    end
  end

  // Reset forces IDLE asynchronously, so a write pending in ACK is discarded.
  always_ff @(posedge clk_i) begin
    if ((r_state == ST_ACK) && r_write) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign ack_o  = r_ack;
  assign data_o = r_data;

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder: vector table plus corner-case sequences,
// with a scoreboard queue matching every ack_o against the expected data_o.
module tb_data_memory_responder;

  logic         clk_i    = 1'b0;
  logic         rst_i    = 1'b0;
  logic         enable_i = 1'b0;
  logic         write_i  = 1'b0;
  logic [31:0]  addr_i   = '0;
  logic [255:0] data_i   = '0;
  logic         ack_o;
  logic [255:0] data_o;

  int checks = 0;
  int errors = 0;

  logic [255:0] sb_q [$];
  logic [255:0] mon_exp;

  localparam logic [255:0] PAT_A5 = {32{8'hA5}};
  localparam logic [255:0] V0     = {16{16'h0F0F}};
  localparam logic [255:0] V1     = {8{32'hC0DE_0001}};
  localparam logic [255:0] V511   = {4{64'hDEAD_BEEF_0123_4567}};
  localparam logic [255:0] V1234  = 256'h1234;

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
    logic [255:0] exp;
  } vec_t;

  vec_t vecs [9];

  always #5 clk_i = ~clk_i;

  data_memory_responder dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .enable_i (enable_i),
    .write_i  (write_i),
    .addr_i   (addr_i),
    .data_i   (data_i),
    .ack_o    (ack_o),
    .data_o   (data_o)
  );

  task automatic check(input bit ok, input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  always @(negedge clk_i) begin
    if (ack_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: ack_o high with no request outstanding at %0t", $time);
      end else begin
        mon_exp = sb_q.pop_front();
        check(data_o === mon_exp, "sb_data_o", data_o, mon_exp);
      end
    end
  end

  // One request; options: mutate inputs after acceptance, drop enable at cycle drop_at,
  // or assert reset at cycle rst_at (10 = during ACK).
  task automatic do_req(input string name, input bit wr, input logic [31:0] addr,
                        input logic [255:0] wdata, input logic [255:0] exp,
                        input bit mutate = 1'b0, input int drop_at = 0, input int rst_at = 0);
    int c;
    bit got;
    int acks;
    @(negedge clk_i);
    enable_i = 1'b1;
    write_i  = wr;
    addr_i   = addr;
    data_i   = wdata;
    if (drop_at == 0 && (rst_at == 0 || rst_at == 10)) sb_q.push_back(wr ? 256'd0 : exp);
    @(posedge clk_i);
    c   = 0;
    got = 1'b0;
    while (!got && c < 30) begin
      @(negedge clk_i);
      c++;
      if (mutate && c == 1) begin
        write_i = ~wr;
        addr_i  = 32'h0000_0080;
        data_i  = '1;
      end
      if (ack_o === 1'b1) got = 1'b1;
      if (c == drop_at) begin
        enable_i = 1'b0;
        acks = 0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk_i);
          if (ack_o !== 1'b0) acks++;
        end
        check(acks == 0, {name, "_no_ack"}, 256'(acks), 256'd0);
        return;
      end
      if (c == rst_at) begin
        #2 rst_i = 1'b0;
        #1;
        check(ack_o === 1'b0, {name, "_rst_ack"}, 256'(ack_o), 256'd0);
        check(data_o === 256'd0, {name, "_rst_data"}, data_o, 256'd0);
        enable_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        return;
      end
    end
    check(got && c == 10, {name, "_latency"}, 256'(c), 256'd10);
    if (!got && sb_q.size() != 0) sb_q.delete();
    enable_i = 1'b0;
    @(negedge clk_i);
    check(ack_o === 1'b0, {name, "_ack_pulse"}, 256'(ack_o), 256'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int t1;
    int t2;

    vecs[0] = '{1'b0, 32'h0000_0060, '0,   PAT_A5};
    vecs[1] = '{1'b1, 32'h0000_4020, V1,   '0};
    vecs[2] = '{1'b0, 32'h0000_0020, '0,   V1};
    vecs[3] = '{1'b1, 32'h0000_0000, V0,   '0};
    vecs[4] = '{1'b0, 32'h0000_001F, '0,   V0};
    vecs[5] = '{1'b1, 32'hFFFF_FFE0, V511, '0};
    vecs[6] = '{1'b0, 32'h0000_3FE0, '0,   V511};
    vecs[7] = '{1'b0, 32'h0000_4060, '0,   PAT_A5};
    vecs[8] = '{1'b0, 32'h0000_0020, '0,   V1};

    dut.r_mem[3] = PAT_A5;
    #12;
    check(ack_o === 1'b0, "reset_ack", 256'(ack_o), 256'd0);
    check(data_o === 256'd0, "reset_data", data_o, 256'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    for (int i = 0; i < 9; i++) begin
      do_req($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].exp);
    end

    // Back-to-back with enable_i held: write 0x80 then read 0x9F.
    @(negedge clk_i);
    enable_i = 1'b1;
    write_i  = 1'b1;
    addr_i   = 32'h0000_0080;
    data_i   = V1234;
    sb_q.push_back(256'd0);
    sb_q.push_back(V1234);
    @(posedge clk_i);
    c  = 0;
    t1 = 0;
    t2 = 0;
    while (c < 40 && t2 == 0) begin
      @(negedge clk_i);
      c++;
      if (ack_o === 1'b1) begin
        if (t1 == 0) begin
          t1 = c;
          write_i = 1'b0;
          addr_i  = 32'h0000_009F;
          data_i  = '0;
        end else begin
          t2 = c;
        end
      end
    end
    check(t1 == 10, "b2b_first_latency", 256'(t1), 256'd10);
    check(t2 - t1 == 11, "b2b_spacing", 256'(t2 - t1), 256'd11);
    if (t2 == 0) sb_q.delete();
    enable_i = 1'b0;
    @(negedge clk_i);
    check(ack_o === 1'b0, "b2b_ack_pulse", 256'(ack_o), 256'd0);

    // Inputs changed after acceptance are ignored; line 4 must keep 0x1234.
    do_req("mutate", 1'b0, 32'h0000_0060, '0, PAT_A5, 1'b1);
    do_req("mutate_line4", 1'b0, 32'h0000_0080, '0, V1234);

    // Abort in WAIT: no ack, no write.
    do_req("abort", 1'b1, 32'h0000_0060, {8{32'hFFFF_0000}}, '0, 1'b0, 5);
    do_req("abort_line3", 1'b0, 32'h0000_0060, '0, PAT_A5);

    // Reset mid-WAIT of a write, then a fresh read.
    do_req("rst_wait", 1'b1, 32'h0000_0060, {8{32'h0000_BEEF}}, '0, 1'b0, 0, 4);
    do_req("rst_wait_line3", 1'b0, 32'h0000_0060, '0, PAT_A5);

    // Reset during ACK of a write discards the write.
    do_req("rst_ack", 1'b1, 32'h0000_0060, {8{32'h0000_DEAD}}, '0, 1'b0, 0, 10);
    do_req("rst_ack_line3", 1'b0, 32'h0000_0060, '0, PAT_A5);

    repeat (3) @(negedge clk_i);
    check(sb_q.size() == 0, "sb_drained", 256'(sb_q.size()), 256'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
